jet_sprite_fetch: RTL and testbench
===================================

Name: jet_sprite_fetch

Overview:
Upstream feeder of the jet palette lookup. It maps the VGA raster position onto the jet sprite's pixel ROM and fetches the 4-bit colour index for each pixel. It delivers that index, plus a hit/opaque flag, to the palette stage and the colour mux with fixed pipeline alignment. It also owns the jet's hit-blink (invulnerability) state machine, so the palette stage only ever sees indices for visible frames.

Parameters:
SPRITE_DIM, 32, sprite width and height in pixels (square sprite, power of two)
ADDR_W, 10, ROM address width, equal to log2(SPRITE_DIM*SPRITE_DIM)
TRANSPARENT_IDX, 4'h0, colour index treated as see-through
BLINK_FRAMES, 120, frames of invulnerability after a hit
BLINK_SHIFT, 3, sprite shown when frame-counter bit [BLINK_SHIFT] is 0

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
jet_x  in  10  sprite top-left X, screen coordinates
jet_y  in  10  sprite top-left Y, screen coordinates
orient  in  2  00 up, 01 right, 10 down, 11 left
hit_pulse  in  1  one-cycle pulse: jet was struck
draw_x  in  10  current raster X
draw_y  in  10  current raster Y
pix_valid  in  1  active-video qualifier for draw_x/draw_y
rom_addr  out  ADDR_W  registered address to the synchronous sprite ROM
rom_q  in  4  ROM data, valid one cycle after rom_addr is sampled
pal_index  out  4  colour index to the palette stage
pix_hit  out  1  sprite pixel present and opaque
pix_out_valid  out  1  pix_valid delayed to align with pal_index
invuln  out  1  high while in the BLINK state

Behaviour:
- Reset (async assert, sync release) forces: rom_addr=0, pal_index=0, pix_hit=0, pix_out_valid=0, invuln=0, FSM=ALIVE, frame counter=0, latched position/orient=0.
- Frame latch: jet_x, jet_y and orient are captured only on frame_start, so there is no mid-frame tearing. After reset, the sprite renders at (0,0)/up until the first frame_start.
- Box test, done in 11-bit arithmetic (no 10-bit wrap):
  - lx = draw_x - jx_l; ly = draw_y - jy_l.
  - inbox = pix_valid & draw_x>=jx_l & draw_x<jx_l+SPRITE_DIM & the same conditions for Y.
  - A sprite partially off the right or bottom edge is simply clipped.
- Orientation transform, with M = SPRITE_DIM-1:
  - up: (lx, ly)
  - right: (ly, M-lx)
  - down: (M-lx, M-ly)
  - left: (M-ly, lx)
  - Address = v*SPRITE_DIM + u.
- Pipeline, with inputs sampled in cycle T:
  - End of T: rom_addr registered. It is forced to 0 when not inbox. Sideband registered: inbox, pix_valid, visible.
  - End of T+1: ROM samples rom_addr. rom_q is valid during T+2. Sideband advances one stage.
  - End of T+2: pal_index <= rom_q. pix_hit <= inbox & visible & (rom_q != TRANSPARENT_IDX). pix_out_valid <= pix_valid.
  - Total latency is 3 cycles, fixed; there is no stall or backpressure.
  - When pix_hit=0, pal_index is still rom_q; consumers must ignore it.
- Blink FSM, 2 states:
  - ALIVE:
    - visible=1, invuln=0.
    - hit_pulse -> BLINK, frame counter cleared to 0.
  - BLINK:
    - invuln=1.
    - visible = ~fcnt[BLINK_SHIFT].
    - fcnt increments on each frame_start.
    - When fcnt reaches BLINK_FRAMES-1 and frame_start is asserted -> ALIVE.
    - hit_pulse in BLINK is ignored; the counter is not restarted.
- Simultaneous events:
  - hit_pulse and frame_start in the same cycle while ALIVE: enter BLINK with fcnt=0. That frame_start does not count.
  - visible is sampled at stage 0. A state change mid-frame affects pixels from the next cycle, but is normally frame-aligned.
- Reset mid-line: the pipeline flushes to zeros. There are no spurious pix_hit for 3 cycles after release.

Decomposition:
- Shared package jet_pkg holds:
  - sprite constants: SPRITE_DIM, ADDR_W, TRANSPARENT_IDX
  - orient enum typedef: ORIENT_UP, ORIENT_RIGHT, ORIENT_DOWN, ORIENT_LEFT
  - blink-state enum: ST_ALIVE, ST_BLINK
- One sub-module is natural: jet_blink_fsm, which owns the state, the frame counter, and the visible/invuln outputs.
- Address transform and pipeline stay in the top module.

Test Plan:
- Reset, frame_start with jet=(100,50), orient=up, raster draw (100,50) -> rom_addr=0 one cycle later; ROM word 0=4'h3 -> pal_index=3, pix_hit=1 exactly 3 cycles after the input.
- Same position, draw (131,81) -> rom_addr=1023. Draw (132,50) -> pix_hit=0 at T+3.
- orient=down, draw (100,50) -> rom_addr=1023. orient=right, draw (101,50) (lx=1, ly=0) -> rom_addr=30*32+0=960.
- ROM returns TRANSPARENT_IDX for an in-box pixel -> pix_hit=0, pal_index=0, pix_out_valid=1.
- jet=(620,470), draw (639,479) -> pix_hit possible, rom_addr=(9*32+19)=307. Draw (0,0) -> no false hit (no wrap).
- hit_pulse -> invuln=1; pix_hit suppressed on frames 8-15, 24-31, …; second hit_pulse during BLINK ignored; after 120 frame_starts invuln=0. Async Reset_n low mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/jet_pkg.sv
// Shared constants and enums for the jet sprite fetch path.
package jet_pkg;
  localparam int SPRITE_DIM = 32;
  localparam int ADDR_W = 10;
  localparam int COORD_W = $clog2(SPRITE_DIM);
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'b00,
    ORIENT_RIGHT = 2'b01,
    ORIENT_DOWN  = 2'b10,
    ORIENT_LEFT  = 2'b11
  } orient_e;

  typedef enum logic {
    ST_ALIVE = 1'b0,
    ST_BLINK = 1'b1
  } blink_state_e;
endpackage

// File: rtl/jet_blink_fsm.sv
// Hit-blink (invulnerability) state machine: frame counter plus visible/invuln flags.
module jet_blink_fsm
  import jet_pkg::*;
#(
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_SHIFT  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic hit_pulse,
  output logic visible,
  output logic invuln
);
  localparam int FCNT_W = $clog2(BLINK_FRAMES);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  blink_state_e      state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              visible_q, visible_d;
  logic              invuln_q, invuln_d;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_ALIVE: begin
        // A frame_start coinciding with the hit is not counted.
        if (hit_pulse) begin
          state_d = ST_BLINK;
          fcnt_d  = '0;
        end
      end
      ST_BLINK: begin
        if (frame_start) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d = ST_ALIVE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      default: state_d = ST_ALIVE;
    endcase
    visible_d = (state_d == ST_ALIVE) | ~fcnt_d[BLINK_SHIFT];
    invuln_d  = (state_d == ST_BLINK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ALIVE;
      fcnt_q    <= '0;
      visible_q <= 1'b1;
      invuln_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      visible_q <= visible_d;
      invuln_q  <= invuln_d;
    end
  end

  assign visible = visible_q;
  assign invuln  = invuln_q;
endmodule

// File: rtl/jet_sprite_fetch.sv
// Maps the raster onto the jet sprite ROM and delivers colour index + hit flag
// with a fixed 3-cycle latency.
module jet_sprite_fetch
  import jet_pkg::*;
#(
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_SHIFT  = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        jet_x,
  input  logic [9:0]        jet_y,
  input  logic [1:0]        orient,
  input  logic              hit_pulse,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  output logic              pix_hit,
  output logic              pix_out_valid,
  output logic              invuln
);
  localparam logic [COORD_W-1:0] M = COORD_W'(SPRITE_DIM - 1);

  logic [9:0]        jx_q, jx_d, jy_q, jy_d;
  orient_e           orient_q, orient_d;
  logic              visible;
  logic              inbox;
  logic [COORD_W-1:0] lx, ly, u, v;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_inbox_q, s1_valid_q, s1_vis_q;
  logic              s2_inbox_q, s2_valid_q, s2_vis_q;
  logic [3:0]        pal_index_q, pal_index_d;
  logic              pix_hit_q, pix_hit_d;
  logic              pix_out_valid_q;

  jet_blink_fsm #(
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_SHIFT (BLINK_SHIFT)
  ) u_blink (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_start(frame_start),
    .hit_pulse  (hit_pulse),
    .visible    (visible),
    .invuln     (invuln)
  );

  always_comb begin
    jx_d     = jx_q;
    jy_d     = jy_q;
    orient_d = orient_q;
    if (frame_start) begin
      jx_d     = jet_x;
      jy_d     = jet_y;
      orient_d = orient_e'(orient);
    end

    // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping.
    inbox = pix_valid
          & ({1'b0, draw_x} >= {1'b0, jx_q})
          & ({1'b0, draw_x} <  ({1'b0, jx_q} + 11'(SPRITE_DIM)))
          & ({1'b0, draw_y} >= {1'b0, jy_q})
          & ({1'b0, draw_y} <  ({1'b0, jy_q} + 11'(SPRITE_DIM)));
    lx = draw_x[COORD_W-1:0] - jx_q[COORD_W-1:0];
    ly = draw_y[COORD_W-1:0] - jy_q[COORD_W-1:0];

    u = lx;
    v = ly;
    case (orient_q)
      ORIENT_UP:    begin u = lx;     v = ly;     end
      ORIENT_RIGHT: begin u = ly;     v = M - lx; end
      ORIENT_DOWN:  begin u = M - lx; v = M - ly; end
      ORIENT_LEFT:  begin u = M - ly; v = lx;     end
      default:      begin u = lx;     v = ly;     end
    endcase
    rom_addr_d = inbox ? {v, u} : '0;

    pal_index_d = rom_q;
    pix_hit_d   = s2_inbox_q & s2_vis_q & (rom_q != TRANSPARENT_IDX);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      jx_q            <= '0;
      jy_q            <= '0;
      orient_q        <= ORIENT_UP;
      rom_addr_q      <= '0;
      s1_inbox_q      <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_vis_q        <= 1'b0;
      s2_inbox_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      s2_vis_q        <= 1'b0;
      pal_index_q     <= '0;
      pix_hit_q       <= 1'b0;
      pix_out_valid_q <= 1'b0;
    end else begin
      jx_q            <= jx_d;
      jy_q            <= jy_d;
      orient_q        <= orient_d;
      rom_addr_q      <= rom_addr_d;
      s1_inbox_q      <= inbox;
      s1_valid_q      <= pix_valid;
      s1_vis_q        <= visible;
      s2_inbox_q      <= s1_inbox_q;
      s2_valid_q      <= s1_valid_q;
      s2_vis_q        <= s1_vis_q;
      pal_index_q     <= pal_index_d;
      pix_hit_q       <= pix_hit_d;
      pix_out_valid_q <= s2_valid_q;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign pal_index     = pal_index_q;
  assign pix_hit       = pix_hit_q;
  assign pix_out_valid = pix_out_valid_q;
endmodule

// File: tb/tb_jet_sprite_fetch.sv
// Directed bench for jet_sprite_fetch with a behavioural synchronous sprite ROM.
module tb_jet_sprite_fetch;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] jet_x = '0, jet_y = '0;
  logic [1:0] orient = 2'b00;
  logic       hit_pulse = 1'b0;
  logic [9:0] draw_x = '0, draw_y = '0;
  logic       pix_valid = 1'b0;
  logic [9:0] rom_addr;
  logic [3:0] rom_q = 4'h0;
  logic [3:0] pal_index;
  logic       pix_hit, pix_out_valid, invuln;

  logic [3:0] rom [0:1023];
  int errors = 0;
  int checks = 0;

  jet_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .jet_x(jet_x), .jet_y(jet_y), .orient(orient), .hit_pulse(hit_pulse),
    .draw_x(draw_x), .draw_y(draw_y), .pix_valid(pix_valid),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pix_hit(pix_hit), .pix_out_valid(pix_out_valid), .invuln(invuln)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_q <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one raster sample at a negedge, check rom_addr one cycle later and outputs at T+3.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic v, input logic [9:0] exp_addr, input logic exp_hit);
    logic [3:0] exp_idx;
    exp_idx = rom[exp_addr];
    draw_x = x; draw_y = y; pix_valid = v;
    @(posedge Clk); @(negedge Clk);
    chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    draw_x = '0; draw_y = '0; pix_valid = 1'b0;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    chk({tag, ".hit"}, 32'(pix_hit), 32'(exp_hit));
    chk({tag, ".idx"}, 32'(pal_index), 32'(exp_idx));
    chk({tag, ".pov"}, 32'(pix_out_valid), 32'(v));
    $display("probe %s draw=(%0d,%0d) valid=%0b addr=%0d hit=%0b idx=%0h",
             tag, x, y, v, rom_addr, pix_hit, pal_index);
  endtask

  task automatic frame(input logic with_hit);
    frame_start = 1'b1; hit_pulse = with_hit;
    @(posedge Clk); @(negedge Clk);
    frame_start = 1'b0; hit_pulse = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic set_jet(input logic [9:0] x, input logic [9:0] y, input logic [1:0] o);
    jet_x = x; jet_y = y; orient = o;
    frame(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'((i % 15) + 1);
    rom[0] = 4'h3;

    // Reset state
    #12;
    chk("rst.addr", 32'(rom_addr), 0);
    chk("rst.idx", 32'(pal_index), 0);
    chk("rst.hit", 32'(pix_hit), 0);
    chk("rst.pov", 32'(pix_out_valid), 0);
    chk("rst.invuln", 32'(invuln), 0);
    @(negedge Clk); Reset_n = 1'b1;

    // Before any frame_start the sprite sits at (0,0), up.
    probe("origin", 10'd0, 10'd0, 1'b1, 10'd0, 1'b1);

    set_jet(10'd100, 10'd50, 2'b00);
    probe("up_tl", 10'd100, 10'd50, 1'b1, 10'd0, 1'b1);
    chk("up_tl.idx3", 32'(pal_index), 32'h3);
    probe("up_br", 10'd131, 10'd81, 1'b1, 10'd1023, 1'b1);
    probe("out_r", 10'd132, 10'd50, 1'b1, 10'd0, 1'b0);
    probe("out_l", 10'd99, 10'd50, 1'b1, 10'd0, 1'b0);
    probe("novalid", 10'd100, 10'd50, 1'b0, 10'd0, 1'b0);

    set_jet(10'd100, 10'd50, 2'b10);
    probe("down", 10'd100, 10'd50, 1'b1, 10'd1023, 1'b1);
    set_jet(10'd100, 10'd50, 2'b01);
    probe("right", 10'd101, 10'd50, 1'b1, 10'd960, 1'b1);
    set_jet(10'd100, 10'd50, 2'b11);
    probe("left", 10'd101, 10'd50, 1'b1, 10'd63, 1'b1);

    // Mid-frame position change must not take effect until frame_start.
    jet_x = 10'd300; orient = 2'b00;
    probe("nolatch", 10'd101, 10'd50, 1'b1, 10'd63, 1'b1);

    set_jet(10'd100, 10'd50, 2'b00);
    rom[5] = 4'h0;
    probe("transp", 10'd105, 10'd50, 1'b1, 10'd5, 1'b0);

    set_jet(10'd620, 10'd470, 2'b00);
    probe("edge", 10'd639, 10'd479, 1'b1, 10'd307, 1'b1);
    probe("nowrap", 10'd0, 10'd0, 1'b1, 10'd0, 1'b0);

    // Blink sequence
    set_jet(10'd100, 10'd50, 2'b00);
    hit_pulse = 1'b1; @(posedge Clk); @(negedge Clk); hit_pulse = 1'b0;
    chk("blink.invuln", 32'(invuln), 1);
    probe("blink0", 10'd100, 10'd50, 1'b1, 10'd0, 1'b1);
    frames(8);
    probe("blink8", 10'd100, 10'd50, 1'b1, 10'd0, 1'b0);
    hit_pulse = 1'b1; @(posedge Clk); @(negedge Clk); hit_pulse = 1'b0;
    frames(8);
    probe("blink16", 10'd100, 10'd50, 1'b1, 10'd0, 1'b1);
    frames(8);
    probe("blink24", 10'd100, 10'd50, 1'b1, 10'd0, 1'b0);
    frames(95);
    chk("blink119.invuln", 32'(invuln), 1);
    frames(1);
    chk("blink120.invuln", 32'(invuln), 0);
    probe("alive", 10'd100, 10'd50, 1'b1, 10'd0, 1'b1);

    // Hit together with frame_start: that frame_start is not counted.
    frame(1'b1);
    chk("simul.invuln", 32'(invuln), 1);
    frames(7);
    probe("simul7", 10'd100, 10'd50, 1'b1, 10'd0, 1'b1);
    frames(1);
    probe("simul8", 10'd100, 10'd50, 1'b1, 10'd0, 1'b0);

    // Asynchronous reset mid-line, then no early hit after release.
    draw_x = 10'd101; draw_y = 10'd51; pix_valid = 1'b1;
    @(posedge Clk); #2;
    Reset_n = 1'b0; #1;
    chk("arst.addr", 32'(rom_addr), 0);
    chk("arst.hit", 32'(pix_hit), 0);
    chk("arst.pov", 32'(pix_out_valid), 0);
    chk("arst.invuln", 32'(invuln), 0);
    draw_x = 10'd0; draw_y = 10'd0;
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("rel1.hit", 32'(pix_hit), 0);
    @(posedge Clk); @(negedge Clk);
    chk("rel2.hit", 32'(pix_hit), 0);
    @(posedge Clk); @(negedge Clk);
    chk("rel3.hit", 32'(pix_hit), 1);
    chk("rel3.idx", 32'(pal_index), 32'h3);
    $display("reset release: hit=%0b idx=%0h", pix_hit, pal_index);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
